// File: rtl/ddr2pbuf_gen.sv
// ---------------------------------------------------------------------------
// ddr2pbuf_gen
// Loads the per-PE parameter buffers from one or two DDR beat streams.
// A job is configured by conf_* (captured when start is seen in IDLE) and runs
// in one of three modes:
//   PARAM          : every ddr2 beat is written to all units in conf_grp_mask,
//                    at consecutive addresses 0..conf_trans_num.
//   UPDATE         : ddr1/ddr2 beats are consumed in pairs; ddr1 (gradient)
//                    is written to one unit picked from the pixel/row counters.
//   UPDATE_DEPOOL  : like UPDATE, but each ddr1 lane is zeroed where the
//                    matching ddr2 (pool mask) lane is zero.
// An illegal mode (3) goes straight to FLUSH and ends without any writes.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   start             begin a job (only sampled in IDLE)
//   busy, done        job in progress / one-cycle end-of-job pulse
//   conf_*            job configuration, captured with start
//   ddr1_*            gradient stream (valid/ready handshake)
//   ddr2_*            param / pool-mask stream (valid/ready handshake)
//   pbuf_wr_addr      shared write address
//   pbuf_wr_data      unit j data at [j*DDR_W +: DDR_W]
//   pbuf_wr_en        per-unit write enable
// ---------------------------------------------------------------------------
module ddr2pbuf_gen #(
    parameter int BATCH     = 4,
    parameter int DATA_W    = 16,
    parameter int DDR_W     = BATCH * DATA_W,
    parameter int PE_NUM    = 4,
    parameter int BUF_DEPTH = 256,
    parameter int ADDR_W    = $clog2(BUF_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [1:0]                     conf_mode,
    input  logic [PE_NUM-1:0]              conf_grp_mask,
    input  logic [7:0]                     conf_trans_num,
    input  logic [3:0]                     conf_ch_num,
    input  logic [3:0]                     conf_pix_num,
    input  logic [1:0]                     conf_row_num,
    input  logic [DDR_W-1:0]               ddr1_data,
    input  logic                           ddr1_valid,
    output logic                           ddr1_ready,
    input  logic [DDR_W-1:0]               ddr2_data,
    input  logic                           ddr2_valid,
    output logic                           ddr2_ready,
    output logic [ADDR_W-1:0]              pbuf_wr_addr,
    output logic [PE_NUM*BATCH*DATA_W-1:0] pbuf_wr_data,
    output logic [PE_NUM-1:0]              pbuf_wr_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] MODE_PARAM  = 2'd0;
    localparam logic [1:0] MODE_UPDATE = 2'd1;
    localparam logic [1:0] MODE_DEPOOL = 2'd2;
    localparam logic [1:0] MODE_BAD    = 2'd3;

    localparam logic [PE_NUM-1:0] UNIT0_ONEHOT = {{(PE_NUM-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [PE_NUM-1:0]      grp_mask_q, grp_mask_d;
    logic [7:0]             trans_num_q, trans_num_d;
    logic [3:0]             ch_num_q, ch_num_d;
    logic [3:0]             pix_num_q, pix_num_d;
    logic [1:0]             row_num_q, row_num_d;

    logic [7:0]             cnt_q, cnt_d;
    logic [3:0]             ch_q, ch_d;
    logic [3:0]             pix_q, pix_d;
    logic [1:0]             row_q, row_d;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [PE_NUM*DDR_W-1:0] wr_data_q, wr_data_d;
    logic [PE_NUM-1:0]      wr_en_q, wr_en_d;

    logic                   fire_s;
    logic                   last_s;
    logic                   ddr1_ready_s;
    logic                   ddr2_ready_s;
    logic [ADDR_W-1:0]      addr_s;
    logic [PE_NUM-1:0]      en_s;
    logic [1:0]             unit_s;
    logic [DDR_W-1:0]       beat_s;

    // Handshake: which streams are ready, whether a beat fires, and whether it is the last one.
    always_comb begin
        fire_s       = 1'b0;
        last_s       = 1'b0;
        ddr1_ready_s = 1'b0;
        ddr2_ready_s = 1'b0;
        if (state_q == S_RUN) begin
            case (mode_q)
                MODE_PARAM: begin
                    ddr2_ready_s = 1'b1;
                    fire_s       = ddr2_valid;
                    last_s       = (cnt_q == trans_num_q);
                end
                MODE_UPDATE, MODE_DEPOOL: begin
                    // Each stream is only accepted together with the other one.
                    ddr1_ready_s = ddr2_valid;
                    ddr2_ready_s = ddr1_valid;
                    fire_s       = ddr1_valid & ddr2_valid;
                    last_s       = (ch_q == ch_num_q) && (pix_q == pix_num_q) &&
                                   (row_q == row_num_q);
                end
                default: begin
                    fire_s = 1'b0;
                end
            endcase
        end else begin
            fire_s = 1'b0;
        end
    end

    // Write address and per-unit enables for the beat currently offered.
    always_comb begin
        addr_s = '0;
        en_s   = '0;
        unit_s = {row_q[0], pix_q[0]};
        case (mode_q)
            MODE_PARAM: begin
                addr_s = ADDR_W'(cnt_q);
                en_s   = grp_mask_q;
            end
            MODE_UPDATE, MODE_DEPOOL: begin
                // Even/odd pixel and row pick one of the first four units; the
                // remaining counter bits form the address.
                addr_s = ADDR_W'({ch_q, row_q[1], pix_q[3:1]});
                en_s   = UNIT0_ONEHOT << unit_s;
            end
            default: begin
                en_s = '0;
            end
        endcase
    end

    // Beat payload, with depool masking applied lane by lane.
    always_comb begin
        beat_s = '0;
        case (mode_q)
            MODE_PARAM:  beat_s = ddr2_data;
            MODE_UPDATE: beat_s = ddr1_data;
            MODE_DEPOOL: begin
                for (int i = 0; i < BATCH; i++) begin
                    beat_s[i*DATA_W +: DATA_W] = (ddr2_data[i*DATA_W +: DATA_W] != '0) ?
                                                 ddr1_data[i*DATA_W +: DATA_W] : '0;
                end
            end
            default: beat_s = '0;
        endcase
    end

    // FSM next state, configuration capture and beat counters.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        grp_mask_d  = grp_mask_q;
        trans_num_d = trans_num_q;
        ch_num_d    = ch_num_q;
        pix_num_d   = pix_num_q;
        row_num_d   = row_num_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        pix_d       = pix_q;
        row_d       = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = conf_mode;
                    grp_mask_d  = conf_grp_mask;
                    trans_num_d = conf_trans_num;
                    ch_num_d    = conf_ch_num;
                    pix_num_d   = conf_pix_num;
                    row_num_d   = conf_row_num;
                    cnt_d       = 8'd0;
                    ch_d        = 4'd0;
                    pix_d       = 4'd0;
                    row_d       = 2'd0;
                    if (conf_mode == MODE_BAD) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (fire_s && last_s) begin
                    // Leave the counters at zero so the next job starts clean.
                    state_d = S_FLUSH;
                    cnt_d   = 8'd0;
                    ch_d    = 4'd0;
                    pix_d   = 4'd0;
                    row_d   = 2'd0;
                end else if (fire_s) begin
                    state_d = S_RUN;
                    if (mode_q == MODE_PARAM) begin
                        cnt_d = cnt_q + 8'd1;
                    end else if (ch_q != ch_num_q) begin
                        ch_d = ch_q + 4'd1;
                    end else if (pix_q != pix_num_q) begin
                        ch_d  = 4'd0;
                        pix_d = pix_q + 4'd1;
                    end else begin
                        ch_d  = 4'd0;
                        pix_d = 4'd0;
                        row_d = row_q + 2'd1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output stage: one register between a firing beat and the pbuf write port.
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        // done is registered off the FLUSH state, so it follows the last write by one cycle.
        done_d    = (state_q == S_FLUSH);
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (fire_s) begin
            wr_en_d   = en_s;
            wr_addr_d = addr_s;
            wr_data_d = {PE_NUM{beat_s}};
        end else begin
            wr_en_d = '0;
        end
    end

    // State, configuration, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            grp_mask_q  <= '0;
            trans_num_q <= 8'd0;
            ch_num_q    <= 4'd0;
            pix_num_q   <= 4'd0;
            row_num_q   <= 2'd0;
            cnt_q       <= 8'd0;
            ch_q        <= 4'd0;
            pix_q       <= 4'd0;
            row_q       <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            grp_mask_q  <= grp_mask_d;
            trans_num_q <= trans_num_d;
            ch_num_q    <= ch_num_d;
            pix_num_q   <= pix_num_d;
            row_num_q   <= row_num_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            pix_q       <= pix_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ddr1_ready   = ddr1_ready_s;
    assign ddr2_ready   = ddr2_ready_s;
    assign pbuf_wr_addr = wr_addr_q;
    assign pbuf_wr_data = wr_data_q;
    assign pbuf_wr_en   = wr_en_q;

endmodule

// File: tb/tb_ddr2pbuf_gen.sv
// ---------------------------------------------------------------------------
// tb_ddr2pbuf_gen
// Directed-vector bench for ddr2pbuf_gen with hand-computed expectations.
// A negedge monitor records every pbuf write, done pulses and ready activity;
// each test then compares the recorded sequence against its expected table.
// ---------------------------------------------------------------------------
module tb_ddr2pbuf_gen;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [1:0]   conf_mode;
    logic [3:0]   conf_grp_mask;
    logic [7:0]   conf_trans_num;
    logic [3:0]   conf_ch_num;
    logic [3:0]   conf_pix_num;
    logic [1:0]   conf_row_num;
    logic [63:0]  ddr1_data;
    logic         ddr1_valid;
    logic         ddr1_ready;
    logic [63:0]  ddr2_data;
    logic         ddr2_valid;
    logic         ddr2_ready;
    logic [7:0]   pbuf_wr_addr;
    logic [255:0] pbuf_wr_data;
    logic [3:0]   pbuf_wr_en;

    ddr2pbuf_gen dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .conf_mode      (conf_mode),
        .conf_grp_mask  (conf_grp_mask),
        .conf_trans_num (conf_trans_num),
        .conf_ch_num    (conf_ch_num),
        .conf_pix_num   (conf_pix_num),
        .conf_row_num   (conf_row_num),
        .ddr1_data      (ddr1_data),
        .ddr1_valid     (ddr1_valid),
        .ddr1_ready     (ddr1_ready),
        .ddr2_data      (ddr2_data),
        .ddr2_valid     (ddr2_valid),
        .ddr2_ready     (ddr2_ready),
        .pbuf_wr_addr   (pbuf_wr_addr),
        .pbuf_wr_data   (pbuf_wr_data),
        .pbuf_wr_en     (pbuf_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Monitor record
    logic [7:0]   wq_addr[$];
    logic [3:0]   wq_en[$];
    logic [255:0] wq_data[$];
    int           wq_cyc[$];
    int           done_cnt;
    int           done_cyc;
    bit           seen_r1;
    bit           seen_r2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pbuf_wr_en != 4'd0) begin
            wq_addr.push_back(pbuf_wr_addr);
            wq_en.push_back(pbuf_wr_en);
            wq_data.push_back(pbuf_wr_data);
            wq_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (ddr1_ready) seen_r1 = 1'b1;
        if (ddr2_ready) seen_r2 = 1'b1;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_en.delete();
        wq_data.delete();
        wq_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        seen_r1  = 1'b0;
        seen_r2  = 1'b0;
    endtask

    task automatic start_job(input logic [1:0] mode, input logic [3:0] mask,
                             input logic [7:0] trans, input logic [3:0] ch,
                             input logic [3:0] pix, input logic [1:0] row);
        conf_mode      = mode;
        conf_grp_mask  = mask;
        conf_trans_num = trans;
        conf_ch_num    = ch;
        conf_pix_num   = pix;
        conf_row_num   = row;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    // Offer one beat and hold it until the handshake completes (bounded).
    task automatic send_beat(input bit dual, input logic [63:0] d1, input logic [63:0] d2);
        bit fired;
        fired      = 1'b0;
        ddr1_valid = dual;
        ddr2_valid = 1'b1;
        ddr1_data  = d1;
        ddr2_data  = d2;
        for (int i = 0; i < 20 && !fired; i++) begin
            @(negedge clk);
            if (ddr2_ready && (!dual || ddr1_ready)) fired = 1'b1;
            tick();
        end
        ddr1_valid = 1'b0;
        ddr2_valid = 1'b0;
        chk("beat_accepted", fired, 1'b1);
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        tick();
        chk("done_seen", got, 1'b1);
    endtask

    int          sc;
    logic [63:0] t1_beats[4];
    logic [7:0]  t2_addr[8];
    int          u;

    initial begin
        rst = 1'b0; start = 1'b0;
        conf_mode = 2'd0; conf_grp_mask = 4'd0; conf_trans_num = 8'd0;
        conf_ch_num = 4'd0; conf_pix_num = 4'd0; conf_row_num = 2'd0;
        ddr1_data = 64'd0; ddr1_valid = 1'b0; ddr2_data = 64'd0; ddr2_valid = 1'b0;
        clear_mon();
        tick(); tick();

        // Reset state, with both valids raised so ready must still be held low
        ddr1_valid = 1'b1; ddr2_valid = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdy1", ddr1_ready, 1'b0);
        chk("rst_rdy2", ddr2_ready, 1'b0);
        chk("rst_wr_en", pbuf_wr_en, 4'd0);
        chk("rst_addr", pbuf_wr_addr, 8'd0);
        chk("rst_data", pbuf_wr_data, 256'd0);
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        rst = 1'b1;
        tick();

        // T1: PARAM, mask 0101, 4 beats with a bubble after beat 1
        t1_beats[0] = 64'h1111_2222_3333_4444;
        t1_beats[1] = 64'hA5A5_0000_FFFF_0001;
        t1_beats[2] = 64'h0123_4567_89AB_CDEF;
        t1_beats[3] = 64'hDEAD_BEEF_CAFE_F00D;
        clear_mon();
        start_job(2'd0, 4'b0101, 8'd3, 4'd0, 4'd0, 2'd0);
        chk("t1_busy", busy, 1'b1);
        send_beat(1'b0, 64'd0, t1_beats[0]);
        send_beat(1'b0, 64'd0, t1_beats[1]);
        tick();
        send_beat(1'b0, 64'd0, t1_beats[2]);
        send_beat(1'b0, 64'd0, t1_beats[3]);
        wait_done();
        tick();
        chk("t1_nwr", wq_addr.size(), 4);
        for (int k = 0; k < wq_addr.size() && k < 4; k++) begin
            chk("t1_addr", wq_addr[k], k);
            chk("t1_en", wq_en[k], 4'b0101);
            chk("t1_data_u0", wq_data[k][63:0], t1_beats[k]);
            chk("t1_data_u2", wq_data[k][191:128], t1_beats[k]);
        end
        chk("t1_done_cnt", done_cnt, 1);
        if (wq_cyc.size() == 4) chk("t1_done_cyc", done_cyc, wq_cyc[3] + 1);
        chk("t1_rdy1_never", seen_r1, 1'b0);
        chk("t1_busy_end", busy, 1'b0);

        // T2: UPDATE ch=1 pix=1 row=1, 8 beats
        t2_addr = '{8'd0, 8'd16, 8'd0, 8'd16, 8'd0, 8'd16, 8'd0, 8'd16};
        clear_mon();
        start_job(2'd1, 4'b0000, 8'd0, 4'd1, 4'd1, 2'd1);
        for (int k = 0; k < 8; k++) begin
            send_beat(1'b1, {4{16'h2000 + 16'(k)}}, 64'hFFFF_0000_FFFF_0000);
        end
        wait_done();
        tick();
        chk("t2_nwr", wq_addr.size(), 8);
        for (int k = 0; k < wq_addr.size() && k < 8; k++) begin
            u = k / 2;
            chk("t2_addr", wq_addr[k], t2_addr[k]);
            chk("t2_en", wq_en[k], 4'b0001 << u);
            chk("t2_data", wq_data[k][u*64 +: 64], {4{16'h2000 + 16'(k)}});
        end
        chk("t2_done_cnt", done_cnt, 1);

        // T3: UPDATE_DEPOOL, ch=1 (two beats, lane 0 is the rightmost)
        clear_mon();
        start_job(2'd2, 4'b0000, 8'd0, 4'd1, 4'd0, 2'd0);
        send_beat(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 64'h0001_0000_0005_0000);
        send_beat(1'b1, 64'h1111_2222_3333_4444, 64'h0001_0002_0003_0004);
        wait_done();
        chk("t3_nwr", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            chk("t3_addr0", wq_addr[0], 8'd0);
            chk("t3_en0", wq_en[0], 4'b0001);
            chk("t3_mask0", wq_data[0][63:0], 64'hDDDD_0000_BBBB_0000);
            chk("t3_addr1", wq_addr[1], 8'd16);
            chk("t3_mask1", wq_data[1][63:0], 64'h1111_2222_3333_4444);
        end

        // T4: UPDATE, ddr2 offered alone for 3 cycles, then ddr1 joins
        clear_mon();
        start_job(2'd1, 4'b0000, 8'd0, 4'd0, 4'd0, 2'd0);
        ddr2_valid = 1'b1; ddr2_data = 64'h0000_0000_0000_0007;
        ddr1_valid = 1'b0; ddr1_data = 64'h7777_6666_5555_4444;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_rdy2_low", ddr2_ready, 1'b0);
            chk("t4_rdy1_high", ddr1_ready, 1'b1);
            tick();
        end
        chk("t4_nowr", wq_addr.size(), 0);
        send_beat(1'b1, 64'h7777_6666_5555_4444, 64'h0000_0000_0000_0007);
        wait_done();
        chk("t4_nwr", wq_addr.size(), 1);
        if (wq_addr.size() == 1) begin
            chk("t4_en", wq_en[0], 4'b0001);
            chk("t4_data", wq_data[0][63:0], 64'h7777_6666_5555_4444);
        end

        // T5: start while busy is ignored; reset mid-job aborts
        clear_mon();
        start_job(2'd1, 4'b0000, 8'd0, 4'd1, 4'd1, 2'd1);
        send_beat(1'b1, 64'h0000_0000_0000_00B0, 64'd1);
        send_beat(1'b1, 64'h0000_0000_0000_00B1, 64'd1);
        start_job(2'd0, 4'b1111, 8'd0, 4'd0, 4'd0, 2'd0);
        chk("t5_busy_kept", busy, 1'b1);
        send_beat(1'b1, 64'h0000_0000_0000_00B2, 64'd1);
        tick();
        chk("t5_nwr", wq_addr.size(), 3);
        if (wq_addr.size() == 3) begin
            chk("t5_addr2", wq_addr[2], 8'd0);
            chk("t5_en2", wq_en[2], 4'b0010);
            chk("t5_data2", wq_data[2][127:64], 64'h0000_0000_0000_00B2);
        end
        ddr1_valid = 1'b1; ddr2_valid = 1'b1;
        rst = 1'b0;
        #2;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_wr_en", pbuf_wr_en, 4'd0);
        chk("t5_rst_rdy1", ddr1_ready, 1'b0);
        chk("t5_rst_rdy2", ddr2_ready, 1'b0);
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("t5_no_done", done_cnt, 0);
        clear_mon();
        start_job(2'd0, 4'b1111, 8'd1, 4'd0, 4'd0, 2'd0);
        send_beat(1'b0, 64'd0, 64'h5555_AAAA_5555_AAAA);
        send_beat(1'b0, 64'd0, 64'h0F0F_F0F0_0F0F_F0F0);
        wait_done();
        chk("t5_nwr_new", wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            chk("t5_new_addr0", wq_addr[0], 8'd0);
            chk("t5_new_addr1", wq_addr[1], 8'd1);
            chk("t5_new_en", wq_en[0], 4'b1111);
            chk("t5_new_data_u3", wq_data[1][255:192], 64'h0F0F_F0F0_0F0F_F0F0);
        end

        // T6: illegal mode: done two cycles after start, nothing else moves
        tick();
        clear_mon();
        ddr1_valid = 1'b1; ddr2_valid = 1'b1;
        sc = cyc;
        start_job(2'd3, 4'b1111, 8'd5, 4'd1, 4'd1, 2'd1);
        tick(); tick(); tick(); tick();
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        chk("t6_done_cnt", done_cnt, 1);
        chk("t6_done_cyc", done_cyc, sc + 2);
        chk("t6_nowr", wq_addr.size(), 0);
        chk("t6_rdy1", seen_r1, 1'b0);
        chk("t6_rdy2", seen_r2, 1'b0);
        chk("t6_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
